seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_COUNT, default 100000: clk cycles per digit slot; legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port digits_in, input, 4 x 4-bit unpacked array [3:0]: BCD digits; index 0 is the rightmost digit.
REQ-005 SHALL have port dp_in, input, 4: decimal point per digit, active-high.
REQ-006 SHALL have port load, input, 1: single-cycle strobe that captures digits_in and dp_in.
REQ-007 SHALL have port blank, input, 1: active-high; forces all anodes off.
REQ-008 SHALL have port an, output, 4: anode enables, active-low, one-hot-low.
REQ-009 SHALL have port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp, output, 1: decimal point, active-low.
REQ-011 SHALL have port frame_done, output, 1: one-cycle pulse at each frame boundary.

Function
REQ-012 SHALL count a refresh counter 0..REFRESH_COUNT-1; at REFRESH_COUNT-1 it wraps to 0 and the 2-bit digit index increments modulo 4.
REQ-013 SHALL define a frame boundary as the cycle in which the counter wraps while the index is 3; frame_done is registered high on the next cycle, for that one cycle only.
REQ-014 SHALL capture digits_in/dp_in into a pending buffer and set a pending flag on any cycle with load=1; a later load before commit overwrites the buffer (latest wins).
REQ-015 SHALL copy pending into the active display set and clear the flag at a frame boundary; a load in the boundary cycle itself commits that cycle's digits_in/dp_in directly (bypass).
REQ-016 SHALL never change the active set except at a frame boundary, so a frame never shows mixed old and new digits.
REQ-017 SHALL register all outputs, changing one cycle after the index or active set changes.
REQ-018 SHALL drive an = ~(4'b0001 << index) when blank=0, and 4'b1111 when blank=1; the counter, index and load handling keep running while blanked.
REQ-019 SHALL decode BCD 0-9 to standard active-low patterns (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000).
REQ-020 SHALL decode codes 10-15 to blank, 7'b1111111.
REQ-021 SHALL drive dp = ~active_dp[index].

Reset
REQ-022 SHALL, while reset=1, hold counter=0, index=0, active and pending sets=0, pending flag=0, an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
REQ-023 SHALL discard pending data on reset mid-frame; after release the display shows digit 0 with value 0 on the first edge.

Configuration
REQ-024 SHALL, when macro SEG7_LEADING_ZERO_BLANK_EN is defined, blank digit k (k = 3..1) if it and every higher digit are 0; digit 0 is never blanked; dp is unaffected.
REQ-025 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display all digits, including leading zeros.

Structure
REQ-026 SHALL place the following in package seg7_pkg: bcd_t (4-bit digit typedef), SEG_BLANK = 7'b1111111, and the 16-entry segment pattern constant table.
REQ-027 SHALL implement the decode in sub-module seg7_decoder (bcd_t in, 7-bit out, purely combinational); all state remains in seg7_scan_driver.

Verification (REFRESH_COUNT=4)
REQ-028 SHALL verify: reset release, then load digits {3:1,2:2,1:3,0:4} -> after the first frame_done, an cycles 1110/1101/1011/0111 with 4 cycles each, and seg shows 4/3/2/1.
REQ-029 SHALL verify: load 9-9-9-9 at index 1 mid-frame -> the remaining slots still show old digits; new digits appear only in the slot after frame_done.
REQ-030 SHALL verify: load in the exact boundary cycle -> the next frame shows that cycle's data, and no stale pending value appears in the following frame.
REQ-031 SHALL verify: digit value 12 with dp_in[2]=1 -> seg=7'b1111111 on its slot, and dp=0 on slot 2.
REQ-032 SHALL verify: blank=1 for 10 cycles -> an=4'b1111 throughout; on release, the index equals the un-blanked expected sequence.
REQ-033 SHALL verify: digits {0,0,5,0} (d3..d0) with the macro defined -> slots 3 and 2 are blank and slot 0 shows 0; without the macro, all four slots are shown.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 4-digit seven-segment scan driver.
//   bcd_t      - 4-bit BCD digit
//   SEG_BLANK  - all segments off (active-low)
//   SEG_TABLE  - 16-entry digit-to-segment table, {g,f,e,d,c,b,a}, active-low;
//                codes 10-15 decode to blank
package seg7_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry [n] holds the pattern for code n; the concatenation lists 15 down to 0.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK,     // 15
    SEG_BLANK,     // 14
    SEG_BLANK,     // 13
    SEG_BLANK,     // 12
    SEG_BLANK,     // 11
    SEG_BLANK,     // 10
    7'b0010000,    // 9
    7'b0000000,    // 8
    7'b1111000,    // 7
    7'b0000010,    // 6
    7'b0010010,    // 5
    7'b0011001,    // 4
    7'b0110000,    // 3
    7'b0100100,    // 2
    7'b1111001,    // 1
    7'b1000000     // 0
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: bundles the display-data inputs and the scanned outputs
// of seg7_scan_driver.
//   master - producer of digits/dp/load/blank, consumer of an/seg/dp/frame_done
//   slave  - the scan driver side
interface seg7_scan_driver_if;

  seg7_pkg::bcd_t digits_in [3:0];
  logic [3:0]     dp_in;
  logic           load;
  logic           blank;
  logic [3:0]     an;
  logic [6:0]     seg;
  logic           dp;
  logic           frame_done;

  modport master (
    output digits_in, dp_in, load, blank,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  digits_in, dp_in, load, blank,
    output an, seg, dp, frame_done
  );

endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: purely combinational BCD to seven-segment decode.
//   bcd - input digit code (0-15)
//   seg - {g,f,e,d,c,b,a}, active-low; codes 10-15 give all segments off
module seg7_decoder
  import seg7_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode display.
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   digits_in/dp_in - BCD digits and decimal points, index 0 = rightmost digit
//   load            - strobe capturing digits_in/dp_in into a pending buffer
//   blank           - forces all anodes off; scanning and loading continue
//   an, seg, dp     - active-low anodes, segments {g..a} and decimal point
//   frame_done      - one-cycle pulse after each full 4-digit scan
// Parameter REFRESH_COUNT: clk cycles per digit slot (>= 2).
// Build option: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 always shown, decimal points unaffected).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_COUNT = 100000
)
(
  input  logic       clk,
  input  logic       reset,
  input  bcd_t       digits_in [3:0],
  input  logic [3:0] dp_in,
  input  logic       load,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned     CW       = $clog2(REFRESH_COUNT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(REFRESH_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  bcd_t          act_dig_q [3:0];
  bcd_t          act_dig_d [3:0];
  logic [3:0]    act_dp_q, act_dp_d;
  bcd_t          pend_dig_q [3:0];
  bcd_t          pend_dig_d [3:0];
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_vld_q, pend_vld_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fd_q, fd_d;

  logic          wrap;
  logic          boundary;
  logic          lz_blank;
  logic [6:0]    dec_seg;

  // Scan timing and buffer management
  always_comb begin
    wrap       = (cnt_q == CNT_LAST);
    boundary   = wrap && (idx_q == 2'd3);
    cnt_d      = wrap ? '0 : cnt_q + CW'(1);
    idx_d      = wrap ? idx_q + 2'd1 : idx_q;
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    act_dig_d  = act_dig_q;
    act_dp_d   = act_dp_q;
    if (boundary) begin
      // A load landing on the boundary itself is newer than anything pending,
      // so it goes straight to the active set and the pending copy is dropped.
      pend_vld_d = 1'b0;
      if (load) begin
        act_dig_d = digits_in;
        act_dp_d  = dp_in;
      end else if (pend_vld_q) begin
        act_dig_d = pend_dig_q;
        act_dp_d  = pend_dp_q;
      end
    end else if (load) begin
      pend_dig_d = digits_in;
      pend_dp_d  = dp_in;
      pend_vld_d = 1'b1;
    end
  end

  seg7_decoder u_dec (
    .bcd (act_dig_q[idx_q]),
    .seg (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  always_comb begin
    lz_blank = 1'b0;
    case (idx_q)
      2'd3:    lz_blank = (act_dig_q[3] == 4'd0);
      2'd2:    lz_blank = (act_dig_q[3] == 4'd0) && (act_dig_q[2] == 4'd0);
      2'd1:    lz_blank = (act_dig_q[3] == 4'd0) && (act_dig_q[2] == 4'd0)
                          && (act_dig_q[1] == 4'd0);
      default: lz_blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    lz_blank = 1'b0;
  end
`endif

  // Output next-state: everything derives from the current index/active set
  // and is registered, so outputs trail those by one cycle.
  always_comb begin
    an_d  = blank ? '1 : ~(4'b0001 << idx_q);
    seg_d = lz_blank ? SEG_BLANK : dec_seg;
    dp_d  = ~act_dp_q[idx_q];
    fd_d  = boundary;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      act_dig_q  <= '{default: '0};
      act_dp_q   <= '0;
      pend_dig_q <= '{default: '0};
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_dig_q  <= act_dig_d;
      act_dp_q   <= act_dp_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver with
// REFRESH_COUNT=4 (4 cycles per slot, 16 cycles per frame).
// Honours SEG7_LEADING_ZERO_BLANK_EN when expecting segment patterns.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic reset;
  int   vec  = 0;
  int   miss = 0;
  int   cyc  = 0;

  logic [3:0] cur_d [4];
  logic [3:0] nxt_d [4];
  logic [3:0] cur_dp, nxt_dp;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.REFRESH_COUNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits_in  (bus.digits_in),
    .dp_in      (bus.dp_in),
    .load       (bus.load),
    .blank      (bus.blank),
    .an         (bus.an),
    .seg        (bus.seg),
    .dp         (bus.dp),
    .frame_done (bus.frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle n after reset release shows slot ((n-1)/4)%4.
  function automatic int slot_of(int c);
    return ((c - 1) / 4) % 4;
  endfunction

  function automatic logic [6:0] pat(logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(int s);
    logic [6:0] p;
    p = pat(cur_d[s]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    begin
      logic lz;
      lz = 1'b1;
      for (int k = 3; k >= s; k--) if (cur_d[k] != 4'd0) lz = 1'b0;
      if (s != 0 && lz) p = 7'b1111111;
    end
`endif
    return p;
  endfunction

  function automatic logic [3:0] exp_an(int s);
    logic [3:0] one;
    one = 4'b0001;
    return bus.blank ? 4'b1111 : ~(one << s);
  endfunction

  task automatic commit();
    for (int i = 0; i < 4; i++) cur_d[i] = nxt_d[i];
    cur_dp = nxt_dp;
  endtask

  task automatic set_in(input logic [3:0] d3, input logic [3:0] d2,
                        input logic [3:0] d1, input logic [3:0] d0,
                        input logic [3:0] dpv);
    bus.digits_in[3] = d3; bus.digits_in[2] = d2;
    bus.digits_in[1] = d1; bus.digits_in[0] = d0;
    bus.dp_in = dpv;
    bus.load  = 1'b1;
    nxt_d[3] = d3; nxt_d[2] = d2; nxt_d[1] = d1; nxt_d[0] = d0;
    nxt_dp = dpv;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin cur_d[i] = '0; nxt_d[i] = '0; end
    cur_dp = '0;
    nxt_dp = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    vec++; if (bus.an !== 4'b1111) begin miss++; $display("FAIL reset_an got %b want 1111", bus.an); end
    vec++; if (bus.seg !== 7'b1111111) begin miss++; $display("FAIL reset_seg got %b want 1111111", bus.seg); end
    vec++; if (bus.dp !== 1'b1) begin miss++; $display("FAIL reset_dp got %b want 1", bus.dp); end
    vec++; if (bus.frame_done !== 1'b0) begin miss++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
    reset = 1'b0;
    cyc = 0;
    clear_model();
  endtask

  task automatic test_load_frame();
    int s;
    set_in(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000);
    tick();
    bus.load = 1'b0;
    vec++; if (bus.an !== 4'b1110) begin miss++; $display("FAIL first_edge_an got %b want 1110", bus.an); end
    vec++; if (bus.seg !== 7'b1000000) begin miss++; $display("FAIL first_edge_seg got %b want 1000000", bus.seg); end
    while (cyc < 32) begin
      tick();
      s = slot_of(cyc);
      vec++; if (bus.an !== exp_an(s)) begin miss++; $display("FAIL load_frame_an cyc=%0d got %b want %b", cyc, bus.an, exp_an(s)); end
      vec++; if (bus.seg !== exp_seg(s)) begin miss++; $display("FAIL load_frame_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg(s)); end
      vec++; if (bus.dp !== ~cur_dp[s]) begin miss++; $display("FAIL load_frame_dp cyc=%0d got %b want %b", cyc, bus.dp, ~cur_dp[s]); end
      vec++; if (bus.frame_done !== (cyc % 16 == 0)) begin miss++; $display("FAIL load_frame_fd cyc=%0d got %b want %b", cyc, bus.frame_done, cyc % 16 == 0); end
      if (cyc % 16 == 0) commit();
    end
  endtask

  task automatic test_mid_frame();
    int s;
    while (cyc < 64) begin
      if (cyc == 37) set_in(4'd9, 4'd9, 4'd9, 4'd9, 4'b0000);
      tick();
      bus.load = 1'b0;
      s = slot_of(cyc);
      vec++; if (bus.an !== exp_an(s)) begin miss++; $display("FAIL mid_frame_an cyc=%0d got %b want %b", cyc, bus.an, exp_an(s)); end
      vec++; if (bus.seg !== exp_seg(s)) begin miss++; $display("FAIL mid_frame_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg(s)); end
      vec++; if (bus.frame_done !== (cyc % 16 == 0)) begin miss++; $display("FAIL mid_frame_fd cyc=%0d got %b want %b", cyc, bus.frame_done, cyc % 16 == 0); end
      if (cyc % 16 == 0) commit();
    end
  endtask

  task automatic test_boundary_load();
    int s;
    while (cyc < 112) begin
      if (cyc == 66) set_in(4'd5, 4'd5, 4'd5, 4'd5, 4'b1111);
      if (cyc == 79) set_in(4'd1, 4'd8, 4'd7, 4'd6, 4'b1001);
      tick();
      bus.load = 1'b0;
      s = slot_of(cyc);
      vec++; if (bus.an !== exp_an(s)) begin miss++; $display("FAIL boundary_an cyc=%0d got %b want %b", cyc, bus.an, exp_an(s)); end
      vec++; if (bus.seg !== exp_seg(s)) begin miss++; $display("FAIL boundary_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg(s)); end
      vec++; if (bus.dp !== ~cur_dp[s]) begin miss++; $display("FAIL boundary_dp cyc=%0d got %b want %b", cyc, bus.dp, ~cur_dp[s]); end
      if (cyc % 16 == 0) commit();
    end
  endtask

  task automatic test_code12_dp();
    int s;
    while (cyc < 144) begin
      if (cyc == 113) set_in(4'd5, 4'd12, 4'd0, 4'd7, 4'b0100);
      tick();
      bus.load = 1'b0;
      s = slot_of(cyc);
      vec++; if (bus.seg !== exp_seg(s)) begin miss++; $display("FAIL code12_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg(s)); end
      vec++; if (bus.dp !== ~cur_dp[s]) begin miss++; $display("FAIL code12_dp cyc=%0d got %b want %b", cyc, bus.dp, ~cur_dp[s]); end
      if (cyc % 16 == 0) commit();
    end
    // Frame 129..144 displayed code 12 on slot 2: spot-check the model itself held it.
    vec++; if (cur_d[2] !== 4'd12 || cur_dp !== 4'b0100) begin miss++; $display("FAIL code12_model got %0d/%b want 12/0100", cur_d[2], cur_dp); end
  endtask

  task automatic test_blank();
    int s;
    while (cyc < 170) begin
      bus.blank = (cyc >= 144 && cyc < 154);
      tick();
      s = slot_of(cyc);
      vec++; if (bus.an !== exp_an(s)) begin miss++; $display("FAIL blank_an cyc=%0d got %b want %b", cyc, bus.an, exp_an(s)); end
      vec++; if (bus.frame_done !== (cyc % 16 == 0)) begin miss++; $display("FAIL blank_fd cyc=%0d got %b want %b", cyc, bus.frame_done, cyc % 16 == 0); end
      if (cyc % 16 == 0) commit();
    end
    bus.blank = 1'b0;
  endtask

  task automatic test_leading_zero();
    int s;
    while (cyc < 208) begin
      if (cyc == 171) set_in(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000);
      tick();
      bus.load = 1'b0;
      s = slot_of(cyc);
      vec++; if (bus.an !== exp_an(s)) begin miss++; $display("FAIL lead_zero_an cyc=%0d got %b want %b", cyc, bus.an, exp_an(s)); end
      vec++; if (bus.seg !== exp_seg(s)) begin miss++; $display("FAIL lead_zero_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg(s)); end
      if (cyc % 16 == 0) commit();
    end
  endtask

  task automatic test_reset_mid_frame();
    int s;
    while (cyc < 214) begin
      if (cyc == 210) set_in(4'd7, 4'd7, 4'd7, 4'd7, 4'b1111);
      tick();
      bus.load = 1'b0;
    end
    reset = 1'b1;
    tick();
    tick();
    vec++; if (bus.an !== 4'b1111) begin miss++; $display("FAIL rst_mid_an got %b want 1111", bus.an); end
    vec++; if (bus.seg !== 7'b1111111) begin miss++; $display("FAIL rst_mid_seg got %b want 1111111", bus.seg); end
    vec++; if (bus.dp !== 1'b1) begin miss++; $display("FAIL rst_mid_dp got %b want 1", bus.dp); end
    reset = 1'b0;
    cyc = 0;
    clear_model();
    while (cyc < 36) begin
      tick();
      s = slot_of(cyc);
      vec++; if (bus.an !== exp_an(s)) begin miss++; $display("FAIL rst_mid_scan_an cyc=%0d got %b want %b", cyc, bus.an, exp_an(s)); end
      vec++; if (bus.seg !== exp_seg(s)) begin miss++; $display("FAIL rst_mid_scan_seg cyc=%0d got %b want %b", cyc, bus.seg, exp_seg(s)); end
      vec++; if (bus.dp !== ~cur_dp[s]) begin miss++; $display("FAIL rst_mid_scan_dp cyc=%0d got %b want %b", cyc, bus.dp, ~cur_dp[s]); end
      if (cyc % 16 == 0) commit();
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.load   = 1'b0;
    bus.blank  = 1'b0;
    bus.dp_in  = '0;
    for (int i = 0; i < 4; i++) bus.digits_in[i] = '0;
    clear_model();
    test_reset();
    test_load_frame();
    test_mid_frame();
    test_boundary_load();
    test_code12_dp();
    test_blank();
    test_leading_zero();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
